ad1939_adc_i2s_deserializer: RTL and testbench

//  Upstream capture stage for the AD1939 codec ADC path. Oversamples abclk/alrclk/asdata1/asdata2 in the system clock.

---
 rtl/ad1939_pkg.sv | 17 +
 rtl/ad1939_adc_i2s_deserializer_if.sv | 12 +
 rtl/ad1939_input_sync.sv | 41 ++++
 rtl/ad1939_adc_i2s_deserializer.sv | 161 ++++++++++++++++
 tb/tb_ad1939_adc_i2s_deserializer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/ad1939_pkg.sv
// Shared AD1939 definitions: channel tags and FSM state encodings for the ADC
// deserializer and the DAC serializer.
package ad1939_pkg;

    localparam logic [1:0] CH_L1 = 2'd0;
    localparam logic [1:0] CH_R1 = 2'd1;
    localparam logic [1:0] CH_L2 = 2'd2;
    localparam logic [1:0] CH_R2 = 2'd3;

    typedef enum logic [1:0] {HUNT, SHIFT, DONE} capture_state_t;
    typedef enum logic [1:0] {EMPTY, SEND1, SEND2} out_state_t;

    function automatic logic [1:0] make_channel(input logic line, input logic lr);
        return {line, lr};
    endfunction

endpackage

// File: rtl/ad1939_adc_i2s_deserializer_if.sv
// Avalon-ST source bundle carrying one channel-tagged audio sample per beat.
interface ad1939_adc_i2s_deserializer_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            channel;
    logic                  valid;
    logic                  ready;

    modport master (output data, channel, valid, input ready);
    modport slave  (input data, channel, valid, output ready);
endinterface

// File: rtl/ad1939_input_sync.sv
// Equal-depth synchronizers for the four codec pins plus a registered abclk
// rising-edge strobe, keeping lr/data aligned with the strobe.
module ad1939_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic abclk,
    input  logic alrclk,
    input  logic asdata1,
    input  logic asdata2,
    output logic bit_event,
    output logic lr_p0,
    output logic sdata1_p0,
    output logic sdata2_p0
);
    // Bit order per stage: {bclk, lr, data1, data2}
    logic [SYNC_STAGES-1:0][3:0] sync_pipe;
    logic                        bclk_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_pipe <= '0;
            bclk_prev <= 1'b0;
            bit_event <= 1'b0;
            lr_p0     <= 1'b0;
            sdata1_p0 <= 1'b0;
            sdata2_p0 <= 1'b0;
        end else begin
            sync_pipe[0] <= {abclk, alrclk, asdata1, asdata2};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
            bclk_prev <= sync_pipe[SYNC_STAGES-1][3];
            bit_event <= sync_pipe[SYNC_STAGES-1][3] & ~bclk_prev;
            lr_p0     <= sync_pipe[SYNC_STAGES-1][2];
            sdata1_p0 <= sync_pipe[SYNC_STAGES-1][1];
            sdata2_p0 <= sync_pipe[SYNC_STAGES-1][0];
        end
    end
endmodule

// File: rtl/ad1939_adc_i2s_deserializer.sv
// AD1939 ADC I2S capture: deserializes both ADC lines and emits channel-tagged
// Avalon-ST beats, with sticky overflow / framing status.
module ad1939_adc_i2s_deserializer
    import ad1939_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int SLOT_BITS   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ad1939_abclk,
    input  logic ad1939_alrclk,
    input  logic ad1939_adc_asdata1,
    input  logic ad1939_adc_asdata2,
    ad1939_adc_i2s_deserializer_if.master source,
    output logic status_overflow,
    output logic status_frame_error,
    input  logic status_clear
);
    localparam int CNT_W = $clog2(SLOT_BITS);
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == cnt_t'(SLOT_BITS - 1)) ? c : c + 1'b1;
    endfunction

    logic bit_event, lr_p0, sdata1_p0, sdata2_p0;

    ad1939_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .abclk     (ad1939_abclk),
        .alrclk    (ad1939_alrclk),
        .asdata1   (ad1939_adc_asdata1),
        .asdata2   (ad1939_adc_asdata2),
        .bit_event (bit_event),
        .lr_p0     (lr_p0),
        .sdata1_p0 (sdata1_p0),
        .sdata2_p0 (sdata2_p0)
    );

    capture_state_t        cap_state, cap_next;
    out_state_t            out_state, out_next;
    logic [DATA_WIDTH-1:0] sh1, sh2, hold1, hold2;
    cnt_t                  bit_cnt;
    logic                  lr_prev, primed, word_lr, hold_lr;
    logic                  lr_evt, word_done, frame_err_evt, overflow_evt;

    // The first bit event after reset only primes lr_prev, so no false lr edge is seen
    assign lr_evt = bit_event && primed && (lr_p0 != lr_prev);

    always_ff @(posedge clk) begin
        if (reset) cap_state <= HUNT;
        else       cap_state <= cap_next;
    end

    always_comb begin
        cap_next = cap_state;
        case (cap_state)
            HUNT:    if (lr_evt) cap_next = SHIFT;
            SHIFT:   if (lr_evt) cap_next = SHIFT;
                     else if (bit_event && bit_cnt == cnt_t'(DATA_WIDTH - 1)) cap_next = DONE;
            DONE:    if (lr_evt) cap_next = SHIFT;
            default: cap_next = HUNT;
        endcase
    end

    always_comb begin
        word_done     = 1'b0;
        frame_err_evt = 1'b0;
        if (cap_state == SHIFT) begin
            frame_err_evt = lr_evt;
            word_done     = !lr_evt && bit_event && bit_cnt == cnt_t'(DATA_WIDTH - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh1 <= '0; sh2 <= '0; hold1 <= '0; hold2 <= '0;
            bit_cnt <= '0; lr_prev <= 1'b0; primed <= 1'b0;
            word_lr <= 1'b0; hold_lr <= 1'b0;
        end else begin
            if (bit_event) begin
                primed  <= 1'b1;
                lr_prev <= lr_p0;
                if (lr_evt) begin
                    bit_cnt <= '0;
                    sh1     <= '0;
                    sh2     <= '0;
                    word_lr <= lr_p0;
                end else if (cap_state == SHIFT) begin
                    sh1     <= {sh1[DATA_WIDTH-2:0], sdata1_p0};
                    sh2     <= {sh2[DATA_WIDTH-2:0], sdata2_p0};
                    bit_cnt <= bit_cnt + 1'b1;
                end else if (cap_state == DONE) begin
                    bit_cnt <= sat_inc(bit_cnt);
                end
            end
            if (word_done) begin
                hold1   <= {sh1[DATA_WIDTH-2:0], sdata1_p0};
                hold2   <= {sh2[DATA_WIDTH-2:0], sdata2_p0};
                hold_lr <= word_lr;
            end
        end
    end

    // A new word arriving while beats are still queued restarts at SEND1,
    // except when it coincides with the final accept of SEND2.
    assign overflow_evt = word_done &&
                          (out_state == SEND1 || (out_state == SEND2 && !source.ready));

    always_ff @(posedge clk) begin
        if (reset) out_state <= EMPTY;
        else       out_state <= out_next;
    end

    always_comb begin
        out_next = out_state;
        case (out_state)
            EMPTY:   if (word_done) out_next = SEND1;
            SEND1:   if (word_done) out_next = SEND1;
                     else if (source.ready) out_next = SEND2;
            SEND2:   if (word_done) out_next = SEND1;
                     else if (source.ready) out_next = EMPTY;
            default: out_next = EMPTY;
        endcase
    end

    always_comb begin
        source.valid   = 1'b0;
        source.data    = '0;
        source.channel = '0;
        case (out_state)
            SEND1: begin
                source.valid   = 1'b1;
                source.data    = hold1;
                source.channel = make_channel(1'b0, hold_lr);
            end
            SEND2: begin
                source.valid   = 1'b1;
                source.data    = hold2;
                source.channel = make_channel(1'b1, hold_lr);
            end
            default: ;
        endcase
    end

    // Sticky flags: a new event outranks a coincident clear
    always_ff @(posedge clk) begin
        if (reset) begin
            status_overflow    <= 1'b0;
            status_frame_error <= 1'b0;
        end else begin
            if (overflow_evt)      status_overflow <= 1'b1;
            else if (status_clear) status_overflow <= 1'b0;
            if (frame_err_evt)     status_frame_error <= 1'b1;
            else if (status_clear) status_frame_error <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ad1939_adc_i2s_deserializer.sv
// Directed bench for the AD1939 ADC I2S deserializer: drives I2S half-frames
// (32 clk per abclk period) and checks beats, latency and status flags.
module tb_ad1939_adc_i2s_deserializer;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic reset, abclk, alrclk, asdata1, asdata2, status_clear;
    logic status_overflow, status_frame_error;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] q_data[$];
    logic [1:0]    q_ch[$];

    ad1939_adc_i2s_deserializer_if #(.DATA_WIDTH(DW)) src ();

    ad1939_adc_i2s_deserializer #(.DATA_WIDTH(DW), .SLOT_BITS(32), .SYNC_STAGES(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .ad1939_abclk       (abclk),
        .ad1939_alrclk      (alrclk),
        .ad1939_adc_asdata1 (asdata1),
        .ad1939_adc_asdata2 (asdata2),
        .source             (src.master),
        .status_overflow    (status_overflow),
        .status_frame_error (status_frame_error),
        .status_clear       (status_clear)
    );

    always #5 clk = ~clk;

    // Record every beat the sink accepts (valid && ready at the coming edge)
    always @(negedge clk) begin
        if (src.valid && src.ready) begin
            q_data.push_back(src.data);
            q_ch.push_back(src.channel);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_beat(input string tag, input logic [1:0] ch, input logic [DW-1:0] d);
        checks++;
        assert (q_data.size() > 0) else begin
            errors++;
            $error("FAIL %s: observed=no beat expected=ch%0d/%06h", tag, ch, d);
        end
        if (q_data.size() > 0) begin
            chk({tag, "_ch"}, 32'(q_ch.pop_front()), 32'(ch));
            chk({tag, "_data"}, 32'(q_data.pop_front()), 32'(d));
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk); #1;
        src.ready = v;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        status_clear = 1'b1;
        @(posedge clk); #1;
        status_clear = 1'b0;
    endtask

    // Slot 0 is the I2S delay slot; slots 1..DW carry MSB first; rest are padding
    task automatic half(input logic lrv, input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                        input int first, input int last, input bit chk_lat);
        for (int k = first; k <= last; k++) begin
            @(negedge clk);
            abclk   = 1'b0;
            alrclk  = lrv;
            asdata1 = (k >= 1 && k <= DW) ? w1[DW-k] : 1'b0;
            asdata2 = (k >= 1 && k <= DW) ? w2[DW-k] : 1'b0;
            repeat (16) @(negedge clk);
            abclk = 1'b1;
            if (chk_lat && k == DW) begin
                repeat (3) @(negedge clk);
                chk("latency_before", 32'(src.valid), 32'd0);
                @(negedge clk);
                chk("latency_rise", 32'(src.valid), 32'd1);
                repeat (11) @(negedge clk);
            end else begin
                repeat (15) @(negedge clk);
            end
        end
    endtask

    initial begin
        reset = 1'b1; abclk = 1'b1; alrclk = 1'b1; asdata1 = 1'b0; asdata2 = 1'b0;
        status_clear = 1'b0; src.ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_valid", 32'(src.valid), 32'd0);
        chk("reset_data", 32'(src.data), 32'd0);
        chk("reset_channel", 32'(src.channel), 32'd0);
        chk("reset_ovf", 32'(status_overflow), 32'd0);
        chk("reset_ferr", 32'(status_frame_error), 32'd0);
        reset = 1'b0;

        // Stream joins mid right half: partial word must be dropped
        half(1'b1, 24'hFFFFFF, 24'hFFFFFF, 12, 31, 1'b0);
        chk("partial_dropped", 32'(q_data.size()), 32'd0);

        // Left then right half with ready held high
        half(1'b0, 24'hABCDEF, 24'h123456, 0, 31, 1'b1);
        expect_beat("left_l1", 2'd0, 24'hABCDEF);
        expect_beat("left_l2", 2'd2, 24'h123456);
        half(1'b1, 24'h800000, 24'h7FFFFF, 0, 31, 1'b0);
        expect_beat("right_r1", 2'd1, 24'h800000);
        expect_beat("right_r2", 2'd3, 24'h7FFFFF);
        chk("right_no_extra", 32'(q_data.size()), 32'd0);
        chk("right_ovf", 32'(status_overflow), 32'd0);
        chk("right_ferr", 32'(status_frame_error), 32'd0);

        // Sink stalls for two half-frames: newer words replace the held ones
        set_ready(1'b0);
        half(1'b0, 24'h111111, 24'h222222, 0, 31, 1'b0);
        chk("stall_valid", 32'(src.valid), 32'd1);
        chk("stall_data", 32'(src.data), 32'h111111);
        chk("stall_ch", 32'(src.channel), 32'd0);
        half(1'b1, 24'h333333, 24'h444444, 0, 31, 1'b0);
        chk("ovf_set", 32'(status_overflow), 32'd1);
        chk("ovf_data", 32'(src.data), 32'h333333);
        chk("ovf_ch", 32'(src.channel), 32'd1);
        chk("ovf_no_beats", 32'(q_data.size()), 32'd0);
        pulse_clear();
        chk("ovf_cleared", 32'(status_overflow), 32'd0);
        set_ready(1'b1);
        repeat (4) @(negedge clk);
        expect_beat("drain_r1", 2'd1, 24'h333333);
        expect_beat("drain_r2", 2'd3, 24'h444444);
        chk("drain_idle", 32'(src.valid), 32'd0);

        // lr toggles after 10 data bits: that half is lost and flagged
        half(1'b0, 24'hAAAAAA, 24'hAAAAAA, 0, 10, 1'b0);
        half(1'b1, 24'h555555, 24'h666666, 0, 31, 1'b0);
        chk("ferr_set", 32'(status_frame_error), 32'd1);
        chk("ferr_no_ovf", 32'(status_overflow), 32'd0);
        expect_beat("ferr_next_r1", 2'd1, 24'h555555);
        expect_beat("ferr_next_r2", 2'd3, 24'h666666);
        chk("ferr_no_extra", 32'(q_data.size()), 32'd0);
        pulse_clear();
        chk("ferr_cleared", 32'(status_frame_error), 32'd0);

        // Reset while a beat is pending: valid drops, capture waits for a fresh lr edge
        set_ready(1'b0);
        half(1'b0, 24'h0A0A0A, 24'h0B0B0B, 0, 31, 1'b0);
        chk("pend_valid", 32'(src.valid), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid", 32'(src.valid), 32'd0);
        chk("rst_data", 32'(src.data), 32'd0);
        reset = 1'b0;
        set_ready(1'b1);
        half(1'b0, 24'hC0FFEE, 24'hC0FFEE, 5, 31, 1'b0);
        chk("rst_partial_dropped", 32'(q_data.size()), 32'd0);
        half(1'b1, 24'h13579B, 24'h2468AC, 0, 31, 1'b0);
        expect_beat("resume_r1", 2'd1, 24'h13579B);
        expect_beat("resume_r2", 2'd3, 24'h2468AC);
        chk("resume_no_extra", 32'(q_data.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
